coin_acceptor: RTL and testbench

Front end of the newspaper vending machine. It turns raw coin-slot sensor levels into the coin[1:0] pulse stream that the vend FSM consumes: 01 nickel, 10 dime, 00 idle. It synchronises and debounces the two sensors, rejects jams and overflow, and queues coins in a small FIFO. A pacing FSM drives each code for a fixed number of cycles, then a mandatory idle gap, so vend never sees back-to-back codes.

---
 rtl/coin_acceptor.sv | 217 +++++++++++++++++++++
 tb/tb_coin_acceptor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the nickel/dime sensors,
// queues qualified coins in a small FIFO and paces them out as coin codes.
module coin_acceptor #(
    parameter int DEBOUNCE     = 3,
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 2,
    parameter int DEPTH        = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       nickel_in,
    input  logic       dime_in,
    input  logic       accept_en,
    output logic [1:0] coin,
    output logic       reject,
    output logic       busy,
    output logic [2:0] pending
);

    localparam logic [3:0] DB_M1     = 4'(DEBOUNCE - 1);
    localparam logic [3:0] DB_MAX    = 4'(DEBOUNCE);
    localparam logic [3:0] PULSE_LEN = 4'(PULSE_CYCLES);
    localparam logic [3:0] GAP_LEN   = 4'(GAP_CYCLES);
    localparam logic [2:0] DEPTH_C   = 3'(DEPTH);
    localparam logic [2:0] LAST_PTR  = 3'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    logic [1:0] raw_w;
    logic [1:0] s_sync;
    logic [1:0] qual;
    logic [1:0] vld_q;
    logic       jam;
    logic       coin_valid;
    logic [1:0] code;
    logic       push;
    logic       pop;
    logic       drop;
    logic       coin_clr;

    assign raw_w = {dime_in, nickel_in};

    // Synchroniser output is only trusted once two post-reset samples have
    // passed through it, so a sensor held high through reset never arms.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= 2'b00;
        end else begin
            vld_q <= {vld_q[0], 1'b1};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic       meta_q;
            logic       sync_q;
            logic [3:0] cnt_q;
            logic [3:0] cnt_d;
            logic       armed_q;
            logic       armed_d;

            assign s_sync[gi] = sync_q;
            assign qual[gi]   = armed_q && sync_q && (cnt_q == DB_M1);

            always_comb begin
                cnt_d   = cnt_q;
                armed_d = armed_q;
                if (!sync_q) begin
                    cnt_d = 4'd0;
                end else if (cnt_q != DB_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
                if (vld_q[1] && !sync_q) begin
                    armed_d = 1'b1;
                end else if (qual[gi] || jam) begin
                    armed_d = 1'b0;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    meta_q  <= 1'b0;
                    sync_q  <= 1'b0;
                    cnt_q   <= 4'd0;
                    armed_q <= 1'b0;
                end else begin
                    meta_q  <= raw_w[gi];
                    sync_q  <= meta_q;
                    cnt_q   <= cnt_d;
                    armed_q <= armed_d;
                end
            end
        end
    endgenerate

    // Both sensors high when either qualifies means two coins in the slot.
    assign jam        = (|qual) && (&s_sync);
    assign coin_valid = (|qual) && !jam;
    assign code       = qual[0] ? 2'b01 : 2'b10;

    logic [1:0] mem [DEPTH];
    logic [2:0] wr_ptr_q;
    logic [2:0] rd_ptr_q;
    logic [2:0] count_q;
    logic [2:0] count_d;

    assign push = coin_valid && accept_en && ((count_q != DEPTH_C) || pop);
    assign drop = coin_valid && !push;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= code;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? 3'd0 : wr_ptr_q + 3'd1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? 3'd0 : rd_ptr_q + 3'd1;
            end
            count_q <= count_d;
        end
    end

    state_t     state_q;
    state_t     state_d;
    logic [3:0] pcnt_q;
    logic [3:0] pcnt_d;
    logic [1:0] coin_q;
    logic       reject_q;
    logic       busy_q;

    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        pop      = 1'b0;
        coin_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != 3'd0) begin
                    pop     = 1'b1;
                    state_d = DRIVE;
                    pcnt_d  = 4'd1;
                end
            end
            DRIVE: begin
                if (pcnt_q == PULSE_LEN) begin
                    coin_clr = 1'b1;
                    state_d  = GAP;
                    pcnt_d   = 4'd1;
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                end
            end
            GAP: begin
                if (pcnt_q == GAP_LEN) begin
                    state_d = IDLE;
                    pcnt_d  = 4'd0;
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                pcnt_d  = 4'd0;
            end
        endcase
    end

    // coin_q doubles as the FIFO's registered read port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            pcnt_q   <= 4'd0;
            coin_q   <= 2'b00;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            reject_q <= drop || jam;
            busy_q   <= (count_d != 3'd0) || (state_d != IDLE);
            if (pop) begin
                coin_q <= mem[rd_ptr_q];
            end else if (coin_clr) begin
                coin_q <= 2'b00;
            end
        end
    end

    assign coin    = coin_q;
    assign reject  = reject_q;
    assign busy    = busy_q;
    assign pending = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a default instance plus a slow-paced
// instance (long pulse/gap) that lets the FIFO fill and overflow.
module tb_coin_acceptor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       nickel;
    logic       dime;
    logic       accept_en;
    logic [1:0] f_coin;
    logic       f_rej;
    logic       f_busy;
    logic [2:0] f_pend;
    logic [1:0] s_coin;
    logic       s_rej;
    logic       s_busy;
    logic [2:0] s_pend;

    coin_acceptor u_dut (
        .clock(clk), .reset(reset), .nickel_in(nickel), .dime_in(dime),
        .accept_en(accept_en), .coin(f_coin), .reject(f_rej),
        .busy(f_busy), .pending(f_pend)
    );

    coin_acceptor #(.PULSE_CYCLES(15), .GAP_CYCLES(15)) u_slow (
        .clock(clk), .reset(reset), .nickel_in(nickel), .dime_in(dime),
        .accept_en(accept_en), .coin(s_coin), .reject(s_rej),
        .busy(s_busy), .pending(s_pend)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Running observations of both instances, sampled at each falling edge.
    int f_nick = 0, f_dime = 0, f_rejn = 0, f_bad = 0, f_pmax = 0;
    int f_zrun = 0, f_wid = 0, f_minw = 99, f_maxw = 0, f_ming = 99, f_had = 0;
    int s_nick = 0, s_dime = 0, s_rejn = 0, s_pmax = 0, over = 0;
    int f_seq[$];
    logic [1:0] f_prev = 2'b00;
    logic [1:0] s_prev = 2'b00;

    task automatic step();
        @(negedge clk);
        if (f_coin == 2'b11 || s_coin == 2'b11) f_bad++;
        if (f_coin != 2'b00) begin
            if (f_prev == 2'b00) begin
                if (f_had != 0 && f_zrun < f_ming) f_ming = f_zrun;
                f_had = 1;
                f_wid = 0;
                f_seq.push_back(int'(f_coin));
                if (f_coin == 2'b01) f_nick++;
                if (f_coin == 2'b10) f_dime++;
            end
            f_wid++;
        end else begin
            if (f_prev != 2'b00) begin
                if (f_wid < f_minw) f_minw = f_wid;
                if (f_wid > f_maxw) f_maxw = f_wid;
                f_zrun = 0;
            end
            f_zrun++;
        end
        if (s_coin != 2'b00 && s_prev == 2'b00) begin
            if (s_coin == 2'b01) s_nick++;
            if (s_coin == 2'b10) s_dime++;
        end
        if (f_rej) f_rejn++;
        if (s_rej) s_rejn++;
        if (int'(f_pend) > f_pmax) f_pmax = int'(f_pend);
        if (int'(s_pend) > s_pmax) s_pmax = int'(s_pend);
        if (f_pend > 3'd4 || s_pend > 3'd4) over++;
        f_prev = f_coin;
        s_prev = s_coin;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int first_nz;
    int bn, bd, br, sbn, sbd, sbr;
    logic [7:0] pat;

    initial begin
        reset = 1'b1; nickel = 1'b0; dime = 1'b0; accept_en = 1'b1;
        steps(3);
        check("rst_coin", int'(f_coin), 0);
        check("rst_reject", int'(f_rej), 0);
        check("rst_busy", int'(f_busy), 0);
        check("rst_pending", int'(f_pend), 0);
        reset = 1'b0;
        steps(4);

        // single nickel held 6 cycles: write at k+4, coin at k+5
        bn = f_nick; br = f_rejn; first_nz = -1;
        nickel = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step();
            if (f_coin != 2'b00 && first_nz < 0) first_nz = j;
            if (j == 3) check("t1_pend_before_write", int'(f_pend), 0);
            if (j == 4) check("t1_pend_after_write", int'(f_pend), 1);
            if (j == 5) nickel = 1'b0;
            if (j == 6) check("t1_coin_after_pulse", int'(f_coin), 0);
            if (j == 7) check("t1_busy_in_gap", int'(f_busy), 1);
            if (j == 8) check("t1_busy_idle", int'(f_busy), 0);
        end
        check("t1_latency", first_nz, 5);
        check("t1_nickels", f_nick - bn, 1);
        check("t1_rejects", f_rejn - br, 0);
        check("t1_pending_end", int'(f_pend), 0);

        // nickel, dime, nickel separated by one low cycle
        f_seq.delete(); f_pmax = 0; br = f_rejn;
        nickel = 1'b1; steps(4); nickel = 1'b0; steps(1);
        dime = 1'b1;   steps(4); dime = 1'b0;   steps(1);
        nickel = 1'b1; steps(4); nickel = 1'b0; steps(20);
        check("t2_count", f_seq.size(), 3);
        if (f_seq.size() == 3) begin
            check("t2_code0", f_seq[0], 1);
            check("t2_code1", f_seq[1], 2);
            check("t2_code2", f_seq[2], 1);
        end
        check("t2_pend_peak", f_pmax, 1);
        check("t2_rejects", f_rejn - br, 0);

        // glitched dime: 2 highs then glitch then 2 highs -> nothing
        f_seq.delete();
        pat = 8'b0001_1011;
        for (int i = 0; i < 6; i++) begin dime = pat[i]; step(); end
        dime = 1'b0; steps(15);
        check("t3_short_none", f_seq.size(), 0);
        // glitch followed by 3 highs -> one dime
        pat = 8'b0011_1011;
        for (int i = 0; i < 6; i++) begin dime = pat[i]; step(); end
        dime = 1'b0; steps(15);
        check("t3_glitch_count", f_seq.size(), 1);
        if (f_seq.size() == 1) check("t3_glitch_code", f_seq[0], 2);

        // jam: both sensors together
        f_seq.delete(); f_pmax = 0; br = f_rejn;
        nickel = 1'b1; dime = 1'b1; steps(5);
        nickel = 1'b0; dime = 1'b0; steps(15);
        check("t4_jam_rejects", f_rejn - br, 1);
        check("t4_jam_coins", f_seq.size(), 0);
        check("t4_jam_pend", f_pmax, 0);

        // accept_en low drops the coin
        f_seq.delete(); f_pmax = 0; br = f_rejn;
        accept_en = 1'b0;
        nickel = 1'b1; steps(4); nickel = 1'b0; steps(10);
        accept_en = 1'b1; steps(5);
        check("t5_disabled_rejects", f_rejn - br, 1);
        check("t5_disabled_coins", f_seq.size(), 0);
        check("t5_disabled_pend", f_pmax, 0);

        // six dimes at 4-cycle spacing; slow instance overflows once
        reset = 1'b1; steps(2); reset = 1'b0; steps(2);
        bd = f_dime; br = f_rejn; sbd = s_dime; sbr = s_rejn; s_pmax = 0;
        for (int i = 0; i < 6; i++) begin
            dime = 1'b1; steps(3); dime = 1'b0; steps(1);
        end
        steps(170);
        check("t6_fast_dimes", f_dime - bd, 6);
        check("t6_fast_rejects", f_rejn - br, 0);
        check("t6_slow_dimes", s_dime - sbd, 5);
        check("t6_slow_rejects", s_rejn - sbr, 1);
        check("t6_slow_pend_peak", s_pmax, 4);
        check("t6_slow_busy_end", int'(s_busy), 0);

        // reset during DRIVE with two queued, nickel held through reset
        for (int i = 0; i < 3; i++) begin
            dime = 1'b1; steps(3); dime = 1'b0; steps(1);
        end
        nickel = 1'b1; steps(2);
        check("t7_pend_before_rst", int'(s_pend), 2);
        check("t7_coin_before_rst", int'(s_coin), 2);
        reset = 1'b1; step();
        check("t7_rst_coin", int'(s_coin), 0);
        check("t7_rst_pend", int'(s_pend), 0);
        check("t7_rst_busy", int'(s_busy), 0);
        reset = 1'b0;
        bn = f_nick; sbn = s_nick; sbd = s_dime;
        steps(40);
        check("t7_held_slow_none", s_nick - sbn, 0);
        check("t7_held_fast_none", f_nick - bn, 0);
        check("t7_discarded_dimes", s_dime - sbd, 0);
        nickel = 1'b0; steps(2); nickel = 1'b1; steps(5); nickel = 1'b0;
        steps(45);
        check("t7_rearm_slow", s_nick - sbn, 1);
        check("t7_rearm_fast", f_nick - bn, 1);

        check("pulse_min_width", f_minw, 1);
        check("pulse_max_width", f_maxw, 1);
        check("pulse_min_gap", f_ming, 3);
        check("code_11_seen", f_bad, 0);
        check("pending_over_depth", over, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
